// File: rtl/bitbrick_pe.sv
// Registered 2x2 multiplier brick with per-operand signedness; four of these plus shift/add build a 4x4 multiply.
// Latency 1 cycle, no backpressure: a valid input is accepted every cycle.
module bitbrick_pe (
  input  logic       clk,
  input  logic       nrst,
  input  logic       in_valid,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] sel,
  output logic [3:0] p,
  output logic       out_valid
);

  logic       a_signed;
  logic       b_signed;
  logic [3:0] a_ext;
  logic [3:0] b_ext;
  logic [3:0] prod;
  logic [3:0] p_d;
  logic [3:0] p_q;
  logic       vld_d;
  logic       vld_q;

  // sel: 00 s*s, 01 u*u, 10 s*u, 11 u*s
  assign a_signed = ~sel[0];
  assign b_signed = ~(sel[1] ^ sel[0]);

  // Low 4 bits of a modulo-16 product equal the low 4 bits of the exact product.
  assign a_ext = {{2{a[1] & a_signed}}, a};
  assign b_ext = {{2{b[1] & b_signed}}, b};
  assign prod  = a_ext * b_ext;

  // Operands are only sampled when qualified, so X on idle inputs never reaches p.
  always_comb begin
    p_d   = p_q;
    vld_d = 1'b0;
    if (in_valid) begin
      p_d   = prod;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      p_q   <= 4'b0000;
      vld_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      vld_q <= vld_d;
    end
  end

  assign p         = p_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_bitbrick_pe.sv
// Scoreboard bench for bitbrick_pe: stimulus pushes expected products, a negedge monitor pops and compares.
module tb_bitbrick_pe;

  logic       clk;
  logic       nrst;
  logic       in_valid;
  logic [1:0] a;
  logic [1:0] b;
  logic [1:0] sel;
  logic [3:0] p;
  logic       out_valid;

  int checks;
  int failures;
  logic [3:0] exp_q[$];
  logic [3:0] seen_q[$];

  bitbrick_pe dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .p         (p),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference: interpret each operand per sel with integer arithmetic.
  function automatic logic [3:0] ref_mul(input logic [1:0] ra, input logic [1:0] rb,
                                         input logic [1:0] rs);
    int av;
    int bv;
    int pr;
    logic [31:0] pw;
    av = int'(ra);
    bv = int'(rb);
    case (rs)
      2'b00: begin if (av > 1) av -= 4; if (bv > 1) bv -= 4; end
      2'b10: begin if (av > 1) av -= 4; end
      2'b11: begin if (bv > 1) bv -= 4; end
      default: ;
    endcase
    pr = av * bv;
    pw = pr;
    return pw[3:0];
  endfunction

  // Monitor: every presented result must match the oldest expected value.
  always @(negedge clk) begin
    if (nrst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {7'b0, out_valid}, 8'h00);
      end else begin
        chk("scoreboard_p", {4'b0, p}, {4'b0, exp_q.pop_front()});
        seen_q.push_back(p);
      end
    end
  end

  task automatic issue(input logic [1:0] ia, input logic [1:0] ib, input logic [1:0] is,
                       input logic [3:0] exp, input bit expect_out);
    a        = ia;
    b        = ib;
    sel      = is;
    in_valid = 1'b1;
    if (expect_out) exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a        = 2'($urandom);
    b        = 2'($urandom);
    sel      = 2'($urandom);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] sum;
    checks   = 0;
    failures = 0;
    nrst     = 1'b1;
    in_valid = 1'b1;
    a = 2'b11; b = 2'b11; sel = 2'b01;
    #1 nrst = 1'b0;
    #1;
    chk("reset_async_p", {4'b0, p}, 8'h00);
    chk("reset_async_vld", {7'b0, out_valid}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      a = 2'($urandom); b = 2'($urandom); sel = 2'($urandom); in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_hold_p", {4'b0, p}, 8'h00);
      chk("reset_hold_vld", {7'b0, out_valid}, 8'h00);
    end
    in_valid = 1'b0;
    nrst     = 1'b1;
    idle();
    chk("post_reset_vld", {7'b0, out_valid}, 8'h00);

    // 4x4 example -5 * 6 split into bricks: ll, hl, lh, hh
    seen_q.delete();
    issue(2'b11, 2'b10, 2'b01, 4'b0110, 1'b1);
    issue(2'b10, 2'b10, 2'b10, 4'b1100, 1'b1);
    issue(2'b01, 2'b11, 2'b10, 4'b0011, 1'b1);
    issue(2'b10, 2'b01, 2'b00, 4'b1110, 1'b1);
    idle();
    @(negedge clk);
    #1;
    chk("paper_count", 8'(seen_q.size()), 8'd4);
    if (seen_q.size() == 4) begin
      sum = ({{4{seen_q[3][3]}}, seen_q[3]} << 4)
          + ({{4{seen_q[1][3]}}, seen_q[1]} << 2)
          + ({{4{seen_q[2][3]}}, seen_q[2]} << 2)
          + {4'b0, seen_q[0]};
      chk("paper_shift_add", sum, 8'b11100010);
    end

    // Mode corners
    issue(2'b10, 2'b10, 2'b00, 4'b0100, 1'b1);
    issue(2'b11, 2'b11, 2'b01, 4'b1001, 1'b1);
    issue(2'b10, 2'b11, 2'b10, 4'b1010, 1'b1);
    issue(2'b11, 2'b10, 2'b11, 4'b1010, 1'b1);

    // Exhaustive back-to-back
    for (int s = 0; s < 4; s++)
      for (int ia = 0; ia < 4; ia++)
        for (int ib = 0; ib < 4; ib++) begin
          issue(2'(ia), 2'(ib), 2'(s), ref_mul(2'(ia), 2'(ib), 2'(s)), 1'b1);
          chk("exhaustive_vld_high", {7'b0, out_valid}, 8'h01);
        end

    // Hold
    issue(2'b11, 2'b11, 2'b01, 4'b1001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("hold_p", {4'b0, p}, 8'b00001001);
      chk("hold_vld", {7'b0, out_valid}, 8'h00);
    end

    // Reset mid-stream: first result lost before the monitor sees it
    issue(2'b10, 2'b10, 2'b00, 4'b0100, 1'b0);
    in_valid = 1'b0;
    #1 nrst = 1'b0;
    #1;
    chk("midreset_p", {4'b0, p}, 8'h00);
    chk("midreset_vld", {7'b0, out_valid}, 8'h00);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    issue(2'b01, 2'b11, 2'b10, 4'b0011, 1'b1);
    chk("after_reset_p", {4'b0, p}, 8'b00000011);
    idle();
    idle();
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bitbrick_pe.md
Name: bitbrick_pe

Overview:
- Registered 2-bit x 2-bit multiplier primitive with a per-operand signedness select.
- Four instances plus external shift/add form a 4x4 signed multiply:
  - low x low: both unsigned
  - high x low and low x high: signed x unsigned
  - high x high: both signed
  - sum = (p_hh<<4) + (p_hl<<2) + (p_lh<<2) + p_ll
- Leaf element of the precision-scalable sparse DNN array.

Parameters:
- None. Operand and product widths are fixed at 2/2/4.

Ports:
- clk  input  1  rising-edge clock
- nrst  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies a, b, sel this cycle
- a  input  2  operand A
- b  input  2  operand B
- sel  input  2  signedness select:
  - 2'b00: A signed, B signed
  - 2'b01: A unsigned, B unsigned
  - 2'b10: A signed, B unsigned
  - 2'b11: A unsigned, B signed
- p  output  4  product, registered
- out_valid  output  1  p holds a new result this cycle

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - nrst low forces p=4'b0000 and out_valid=0 immediately, independent of clk.
  - Deassertion takes effect at the next rising edge.
- Operand extension: each operand is extended to 3 bits.
  - Sign-extended when its select bit marks it signed, giving range -2..1.
  - Zero-extended otherwise, giving range 0..3.
- Arithmetic: the exact product of the extended operands; p = low 4 bits of that product.
  - Signed modes (00, 10, 11): result range -6..4 (signed x signed -2..4; mixed -6..3). Fits in 4-bit two's complement; p is signed.
  - Mode 01: result range 0..9. p must be read as unsigned; 3x3 gives 4'b1001.
  - Consumers sign-extend p only in modes 00, 10 and 11.
- Latency and valid handshake:
  - Latency is 1 cycle.
  - On a rising edge with in_valid=1: p <= product(a, b, sel) and out_valid <= 1.
  - On a rising edge with in_valid=0: p holds its previous value and out_valid <= 0.
  - Back-to-back valid inputs are accepted every cycle; there is no backpressure.
- Reset mid-operation: any in-flight result is discarded; out_valid=0 and p=0 until the first valid input after reset.
- Don't-care inputs: a and b when in_valid=0. X on these must not propagate into p.

Test Plan:
- Reset: nrst=0 asynchronously, with in_valid=1 and random inputs toggling -> p=0 and out_valid=0 with no clock edge required; both stay 0 until released.
- Paper 4x4 example, a=4'b1011 (-5), b=4'b0110 (6), with valid inputs on consecutive cycles:
  - (a=11, b=10, sel=01) -> p=0110
  - (a=10, b=10, sel=10) -> p=1100
  - (a=01, b=11, sel=10) -> p=0011
  - (a=10, b=01, sel=00) -> p=1110
  - Each result appears one cycle after its input.
  - Shift-add of the four results gives 8'b11100010 (-30).
- Mode corners:
  - sel=00, a=10, b=10 -> 0100 (+4)
  - sel=01, a=11, b=11 -> 1001 (9)
  - sel=10, a=10, b=11 -> 1010 (-6)
  - sel=11, a=11, b=10 -> 1010 (-6)
- Exhaustive: all 64 combinations of a, b and sel with continuous in_valid=1 -> every p matches the reference model one cycle later; out_valid stays high throughout.
- Hold: valid input, then in_valid=0 for 3 cycles with random a/b/sel -> p holds, out_valid falls to 0 after one cycle.
- Reset mid-stream: nrst pulsed between two valid inputs -> the result of the first input is lost (p=0, out_valid=0); the second input, applied after release, produces a correct result.
